// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MDU_WAIT, DMEM_WAIT} ctrl_state_e;
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctl_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: flags an ID instruction that reads the destination of a load in EX
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd_addr,
  input  logic       load,
  output logic       load_use
);
  assign load_use = load && rd_addr != REG_ZERO &&
                    ((rs1_used && rs1_addr == rd_addr) || (rs2_used && rs2_addr == rd_addr));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencing for the 5-stage core; PIPE_CTRL_PERF_EN adds perf counters
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_MAX_CYC = 64
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_addr_id,
  input  logic [4:0] rs2_addr_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic [4:0] rd_addr_ex,
  input  logic       load_ex,
  input  logic       redirect_ex,
  input  logic       mdu_start_ex,
  input  logic       mdu_done,
  input  logic       imem_ready,
  input  logic       dmem_req_mem,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic       mdu_busy_o,
  output logic       mdu_err_o
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] stall_cyc_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] mdu_cyc_o
`endif
);
  ctrl_state_e state, next_state;
  stage_ctl_t  if_id, id_ex, ex_mem;
  logic        redir_pend, load_use, run, dmem_stall, mem_hold, mdu_hold;
  logic        redirect_take, lu_take, fetch_wait, wd_hit;
  logic [31:0] wd_cnt;

  pipe_hazard_detect u_hazard (
    .rs1_addr (rs1_addr_id),
    .rs2_addr (rs2_addr_id),
    .rs1_used (rs1_used_id),
    .rs2_used (rs2_used_id),
    .rd_addr  (rd_addr_ex),
    .load     (load_ex),
    .load_use (load_use)
  );

  // Event decode: in RUN only the highest-priority event acts; wait states hold their entry stalls
  always_comb begin
    run           = state == RUN;
    dmem_stall    = dmem_req_mem && !dmem_ready;
    mem_hold      = run ? dmem_stall : state == DMEM_WAIT && !dmem_ready;
    mdu_hold      = run ? !dmem_stall && mdu_start_ex : state == MDU_WAIT && !mdu_done;
    redirect_take = run && !dmem_stall && !mdu_start_ex && redirect_ex;
    lu_take       = run && !dmem_stall && !mdu_start_ex && !redirect_ex && load_use;
    fetch_wait    = run && !dmem_stall && !mdu_start_ex && !redirect_ex && !load_use && !imem_ready;
    wd_hit        = state == MDU_WAIT && !mdu_done && MDU_MAX_CYC != 0 &&
                    wd_cnt == 32'(MDU_MAX_CYC - 1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= next_state;

  // Next-state: MDU exits on done or watchdog, DMEM exits on ready
  always_comb begin
    next_state = run ? (dmem_stall ? DMEM_WAIT : mdu_start_ex ? MDU_WAIT : RUN)
               : state == MDU_WAIT ? ((mdu_done || wd_hit) ? RUN : MDU_WAIT)
               : (dmem_ready ? RUN : DMEM_WAIT);
  end

  // Stage controls; a pending redirect discards whatever IMEM returns until the stale fetch lands
  always_comb begin
    pc_stall     = mem_hold | mdu_hold | lu_take | fetch_wait;
    if_id        = '{stall: mem_hold | mdu_hold | lu_take,
                     flush: redirect_take | fetch_wait | redir_pend};
    id_ex        = '{stall: mem_hold | (mdu_hold && !wd_hit),
                     flush: redirect_take | lu_take | wd_hit};
    ex_mem       = '{stall: mem_hold, flush: mdu_hold};
    mem_wb_flush = mem_hold;
    if_id_stall  = if_id.stall & ~if_id.flush;
    if_id_flush  = if_id.flush;
    id_ex_stall  = id_ex.stall & ~id_ex.flush;
    id_ex_flush  = id_ex.flush;
    ex_mem_stall = ex_mem.stall & ~ex_mem.flush;
    ex_mem_flush = ex_mem.flush;
    mdu_busy_o   = state == MDU_WAIT;
  end

  // Redirect-pending flag, MDU watchdog counter and sticky watchdog error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      redir_pend <= 1'b0;
      wd_cnt     <= '0;
      mdu_err_o  <= 1'b0;
    end else begin
      redir_pend <= (redirect_take && !imem_ready) ? 1'b1 : imem_ready ? 1'b0 : redir_pend;
      wd_cnt     <= (state == MDU_WAIT && next_state == MDU_WAIT) ? wd_cnt + 32'd1 : '0;
      mdu_err_o  <= mdu_err_o | wd_hit;
    end

`ifdef PIPE_CTRL_PERF_EN
  // Free-running wrapping performance counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cyc_o <= '0;
      flush_cnt_o <= '0;
      mdu_cyc_o   <= '0;
    end else begin
      stall_cyc_o <= stall_cyc_o + CNT_W'(pc_stall);
      flush_cnt_o <= flush_cnt_o + CNT_W'(redirect_take);
      mdu_cyc_o   <= mdu_cyc_o + CNT_W'(mdu_busy_o);
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl with directed hazard scenarios
module tb_pipeline_ctrl;
  localparam int MAXC = 12;
  localparam logic [9:0] PC = 10'b1000000000, IFS = 10'b0100000000, IFF = 10'b0010000000,
                         IDS = 10'b0001000000, IDF = 10'b0000100000, EXS = 10'b0000010000,
                         EXF = 10'b0000001000, WBF = 10'b0000000100, BSY = 10'b0000000010,
                         ERR = 10'b0000000001;
  localparam logic [9:0] MDU_H = PC | IFS | IDS | EXF;
  localparam logic [9:0] MEM_H = PC | IFS | IDS | EXS | WBF;

  typedef struct {
    string      nm;
    logic [9:0] e;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic [4:0] rs1_addr_id = 0, rs2_addr_id = 0, rd_addr_ex = 0;
  logic rs1_used_id = 0, rs2_used_id = 0, load_ex = 0, redirect_ex = 0, mdu_start_ex = 0;
  logic mdu_done = 0, imem_ready = 1, dmem_req_mem = 0, dmem_ready = 0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_busy_o, mdu_err_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc_o, flush_cnt_o, mdu_cyc_o;
`endif
  logic [9:0] outv;
  exp_t q[$];
  int total = 0, passed = 0;

  pipeline_ctrl #(.MDU_MAX_CYC(MAXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_addr_ex(rd_addr_ex), .load_ex(load_ex), .redirect_ex(redirect_ex),
    .mdu_start_ex(mdu_start_ex), .mdu_done(mdu_done), .imem_ready(imem_ready),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .mdu_busy_o(mdu_busy_o), .mdu_err_o(mdu_err_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cyc_o(stall_cyc_o), .flush_cnt_o(flush_cnt_o), .mdu_cyc_o(mdu_cyc_o)
`endif
  );

  always #5 clk = ~clk;

  assign outv = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_busy_o, mdu_err_o};

  always @(negedge clk) begin
    exp_t t;
    if (redirect_ex && mdu_start_ex) begin
      total++;
      $display("FAIL illegal_combo: redirect_ex and mdu_start_ex both 1");
    end
    if (q.size() != 0) begin
      t = q.pop_front();
      total++;
      if (outv !== t.e)
        $display("FAIL %s: got %b want %b (pc,ifs,iff,ids,idf,exs,exf,wbf,bsy,err)", t.nm, outv, t.e);
      else passed++;
    end
  end

  task automatic cyc(input string nm, input logic [9:0] e);
    q.push_back('{nm, e});
    @(posedge clk);
    #1;
  endtask

  task automatic mdu_watchdog(input string nm);
    mdu_start_ex = 1;
    cyc({nm, "_start"}, MDU_H);
    mdu_start_ex = 0;
    for (int i = 0; i < MAXC - 1; i++) cyc({nm, "_wait"}, MDU_H | BSY);
    cyc({nm, "_hit"}, PC | IFS | IDF | EXF | BSY);
    cyc({nm, "_err"}, ERR);
    cyc({nm, "_sticky"}, ERR);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 0);
    rst_n = 1;
    cyc("idle", 0);
    load_ex = 1; rd_addr_ex = 5; rs1_addr_id = 5; rs1_used_id = 1;
    cyc("lu_rs1", PC | IFS | IDF);
    load_ex = 0;
    cyc("lu_after", 0);
    load_ex = 1; rd_addr_ex = 0; rs1_addr_id = 0;
    cyc("lu_x0", 0);
    rd_addr_ex = 7; rs2_addr_id = 7; rs2_used_id = 1; rs1_used_id = 0;
    cyc("lu_rs2", PC | IFS | IDF);
    rs2_used_id = 0;
    cyc("lu_unused", 0);
    load_ex = 0;
    redirect_ex = 1; imem_ready = 0;
    cyc("redir_0", IFF | IDF);
    redirect_ex = 0;
    cyc("redir_1", PC | IFF);
    cyc("redir_2", PC | IFF);
    imem_ready = 1;
    cyc("redir_stale", IFF);
    cyc("redir_clear", 0);
    mdu_start_ex = 1;
    cyc("mdu_start", MDU_H);
    mdu_start_ex = 0;
    for (int i = 0; i < 9; i++) cyc("mdu_wait", MDU_H | BSY);
    mdu_done = 1;
    cyc("mdu_done", BSY);
    mdu_done = 0;
    cyc("mdu_exit", 0);
    dmem_req_mem = 1; redirect_ex = 1;
    for (int i = 0; i < 4; i++) cyc("dmem_wait", MEM_H);
    dmem_ready = 1;
    cyc("dmem_ready", 0);
    dmem_req_mem = 0; dmem_ready = 0;
    cyc("dmem_redir", IFF | IDF);
    redirect_ex = 0;
    cyc("dmem_idle", 0);
    mdu_watchdog("wd");
    mdu_start_ex = 1;
    cyc("mid_start", MDU_H | ERR);
    mdu_start_ex = 0;
    for (int i = 0; i < 3; i++) cyc("mid_wait", MDU_H | BSY | ERR);
    rst_n = 0;
    cyc("mid_rst", 0);
    rst_n = 1;
    cyc("mid_after", 0);
    mdu_watchdog("wd2");
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard/sequencing controller for the 5-stage core. It generates the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC hold signal. It handles four hazard sources:
- load-use bubbles
- EX-stage redirects, including wrong-path fetch discard while IMEM is busy
- multi-cycle MDU occupancy, guarded by a watchdog
- DMEM wait states

Parameters:
MDU_MAX_CYC, 64, watchdog limit in cycles for MDU_WAIT; 0 disables the watchdog.
CNT_W, 32, width of the perf counters (optional feature only).

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
rs1_addr_id  in  5  ID rs1 index
rs2_addr_id  in  5  ID rs2 index
rs1_used_id  in  1  ID instr reads rs1
rs2_used_id  in  1  ID instr reads rs2
rd_addr_ex  in  5  EX destination index
load_ex  in  1  EX instr is a load (valid-qualified)
redirect_ex  in  1  EX taken branch/jump/mispredict (valid-qualified)
mdu_start_ex  in  1  EX instr starts multi-cycle MUL/DIV
mdu_done  in  1  MDU result ready (1-cycle pulse)
imem_ready  in  1  IMEM returns fetch this cycle
dmem_req_mem  in  1  MEM stage access pending
dmem_ready  in  1  DMEM completes this cycle
pc_stall  out  1  hold PC
if_id_stall, if_id_flush  out  1 each
id_ex_stall, id_ex_flush  out  1 each
ex_mem_stall, ex_mem_flush  out  1 each
mem_wb_flush  out  1
mdu_busy_o  out  1  state==MDU_WAIT
mdu_err_o  out  1  sticky watchdog error

Behaviour:
- Reset is stated as decided: rst_n is asynchronous and active-low, clk is the clock.
- Reset values: state=RUN, redir_pend=0, wd_cnt=0, mdu_err_o=0.
- Outputs are combinational from the registered state and the current inputs, so with idle inputs after reset every stall/flush is 0.
- States (pipe_ctrl_pkg::ctrl_state_e): RUN, MDU_WAIT, DMEM_WAIT.
- In RUN, events are evaluated in priority order. Only the highest active event takes effect; lower events are re-evaluated next cycle because the stages are frozen.
  1. dmem_req_mem && !dmem_ready: go to DMEM_WAIT this cycle. Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush.
  2. mdu_start_ex: go to MDU_WAIT next cycle. In the start cycle, assert pc_stall, if_id_stall, id_ex_stall and ex_mem_flush.
  3. redirect_ex: assert if_id_flush and id_ex_flush; pc_stall=0 so the PC loads the target. If !imem_ready, set redir_pend.
  4. Load-use, i.e. load_ex && rd_addr_ex!=0 && ((rs1_used_id && rs1_addr_id==rd_addr_ex) || (rs2 likewise)): assert pc_stall, if_id_stall and id_ex_flush. This is exactly one bubble.
  5. !imem_ready: assert pc_stall and if_id_flush, so no valid instr enters ID.
- redir_pend:
  - While redir_pend=1, IF/ID is flushed every cycle.
  - It clears on the first imem_ready; that returning stale fetch is also flushed.
  - A new redirect while pending keeps it set.
- MDU_WAIT:
  - Hold pc_stall, if_id_stall, id_ex_stall and ex_mem_flush every cycle.
  - wd_cnt increments each cycle.
  - On mdu_done: return to RUN and drop all stalls that cycle, so EX/MEM captures the result.
  - If MDU_MAX_CYC!=0 and wd_cnt reaches MDU_MAX_CYC-1 without mdu_done: set mdu_err_o, flush ID/EX and EX/MEM, then go to RUN.
  - wd_cnt clears on exit.
- DMEM_WAIT:
  - Hold the same stalls as entry. redirect_ex and mdu_start_ex are ignored because EX is frozen and stable.
  - On dmem_ready: go to RUN with no stalls that cycle.
- Simultaneous events:
  - mdu_done and dmem stall never coincide, since MEM is empty during MDU_WAIT.
  - redirect_ex && mdu_start_ex is illegal; the bench asserts it never occurs.
- A stage flush always overrides its own stall.

Optional Feature:
PIPE_CTRL_PERF_EN.
- Defined: adds output ports stall_cyc_o, flush_cnt_o, mdu_cyc_o (CNT_W each).
  - stall_cyc_o counts cycles with pc_stall=1.
  - flush_cnt_o counts redirect events.
  - mdu_cyc_o counts MDU_WAIT cycles.
  - All wrap at 2^CNT_W and reset to 0.
- Undefined: no ports and no counters; behaviour is otherwise identical.

Decomposition:
- pipe_ctrl_pkg holds:
  - ctrl_state_e
  - stage_ctl_t struct {stall, flush}
  - localparam REG_ZERO=5'd0
- One natural sub-module, pipe_hazard_detect: a combinational load-use comparator that outputs load_use.

Test Plan:
- After reset: load_ex=1, rd_addr_ex=5, rs1_addr_id=5, rs1_used_id=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle (load_ex=0) all 0. Same case with rd_addr_ex=0 -> no stall.
- redirect_ex=1 with imem_ready=0 for 3 cycles -> if_id_flush=1 on each of those cycles plus the cycle imem_ready=1; redir_pend clears afterwards.
- mdu_start_ex=1, then mdu_done after 10 cycles -> mdu_busy_o=1 for 10 cycles, ex_mem_flush=1 throughout, all stalls 0 in the done cycle.
- MDU_MAX_CYC=8, no mdu_done -> mdu_err_o rises after 8 MDU_WAIT cycles and stays sticky; state returns to RUN.
- dmem_req_mem=1, dmem_ready=0 for 4 cycles while redirect_ex=1 -> stalls and mem_wb_flush held 4 cycles with no flush of IF/ID; redirect flush fires in the cycle after dmem_ready.
- rst_n pulsed low mid-MDU_WAIT -> state returns to RUN, outputs 0, mdu_err_o=0, wd_cnt=0.
